// File: rtl/reset_seq.sv
// Reset sequencer: synchronises PLL lock, stages core/peripheral reset release
// and services a four-phase soft-reset request/acknowledge handshake.
module reset_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 16,
  parameter int STAGGER_CYCLES     = 4,
  parameter int HOLD_CYCLES        = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic locked_i,
  input  logic soft_rst_req_i,
  output logic soft_rst_ack_o,
  output logic rst_core_o,
  output logic rst_periph_o,
  output logic ready_o
);

  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > STAGGER_CYCLES) ? LOCK_STABLE_CYCLES
                                                                  : STAGGER_CYCLES;
  localparam int MAX_CYC = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    STABILISE = 3'd1,
    REL_CORE  = 3'd2,
    RUN       = 3'd3,
    SOFT_HOLD = 3'd4,
    SOFT_ACK  = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   lock_s;
  logic                   rst_core_q, rst_core_d;
  logic                   rst_periph_q, rst_periph_d;
  logic                   ready_q, ready_d;
  logic                   ack_q, ack_d;

  // locked_i is asynchronous; only the last flop of the chain is ever used.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], locked_i};
  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_LOCK: begin
        if (lock_s) state_d = STABILISE;
      end
      STABILISE: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == LOCK_LAST) state_d = REL_CORE;
      end
      REL_CORE: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == STAG_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (soft_rst_req_i)     state_d = SOFT_HOLD;
      end
      SOFT_HOLD: begin
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (cnt_q == HOLD_LAST) state_d = SOFT_ACK;
      end
      SOFT_ACK: begin
        // Lock loss abandons the handshake; ack drops with the WAIT_LOCK entry.
        if (!lock_s)                 state_d = WAIT_LOCK;
        else if (!soft_rst_req_i)    state_d = REL_CORE;
      end
      default: state_d = WAIT_LOCK;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == STABILISE || state_q == REL_CORE || state_q == SOFT_HOLD) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs decode the next state so they switch on the same edge as the state.
  always_comb begin
    rst_core_d   = !(state_d == REL_CORE || state_d == RUN);
    rst_periph_d = (state_d != RUN);
    ready_d      = (state_d == RUN);
    ack_d        = (state_d == SOFT_ACK);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q       <= '0;
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      rst_core_q   <= 1'b1;
      rst_periph_q <= 1'b1;
      ready_q      <= 1'b0;
      ack_q        <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_core_q   <= rst_core_d;
      rst_periph_q <= rst_periph_d;
      ready_q      <= ready_d;
      ack_q        <= ack_d;
    end
  end

  assign rst_core_o     = rst_core_q;
  assign rst_periph_o   = rst_periph_q;
  assign ready_o        = ready_q;
  assign soft_rst_ack_o = ack_q;

endmodule

// File: tb/tb_reset_seq.sv
// Bench for reset_seq: directed vector table, hand-written async-reset sequence,
// then randomized lock/request/reset traffic against an age-based reference model.
module tb_reset_seq;

  localparam int SYNC = 2;
  localparam int LSC  = 16;
  localparam int STG  = 4;
  localparam int HLD  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic locked = 1'b0;
  logic req = 1'b0;
  logic ack, core, periph, ready;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  reset_seq #(
    .SYNC_STAGES(SYNC), .LOCK_STABLE_CYCLES(LSC),
    .STAGGER_CYCLES(STG), .HOLD_CYCLES(HLD)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .locked_i(locked),
    .soft_rst_req_i(req), .soft_rst_ack_o(ack),
    .rst_core_o(core), .rst_periph_o(periph), .ready_o(ready)
  );

  // Reference model: lock_s is locked_i delayed SYNC edges; up_age counts edges
  // since lock_s was first seen high, soft_age counts edges in the soft hold.
  logic [SYNC-1:0] m_sh;
  int  m_up;
  int  m_soft_age;
  bit  m_soft;

  task automatic model_reset();
    m_sh = '0; m_up = -1; m_soft = 0; m_soft_age = 0;
  endtask

  task automatic model_edge(input logic lk, input logic rq);
    logic ls;
    ls   = m_sh[SYNC-1];
    m_sh = {m_sh[SYNC-2:0], lk};
    if (!ls) begin
      m_up = -1; m_soft = 0;
    end else if (m_soft) begin
      if (m_soft_age >= HLD) begin
        if (!rq) begin m_soft = 0; m_up = LSC; end
      end else m_soft_age++;
    end else if (m_up < 0) m_up = 0;
    else if (m_up >= LSC + STG) begin
      if (rq) begin m_soft = 1; m_soft_age = 0; end
    end else m_up++;
  endtask

  task automatic chk(input string nm, input logic c, input logic p, input logic r, input logic a);
    nvec++;
    if (core !== c || periph !== p || ready !== r || ack !== a) begin
      nmis++;
      $display("FAIL %s @%0t: got core=%b periph=%b ready=%b ack=%b, want core=%b periph=%b ready=%b ack=%b",
               nm, $time, core, periph, ready, ack, c, p, r, a);
    end
  endtask

  task automatic chk_model(input string nm);
    logic rel_core, rel_all;
    rel_core = !m_soft && m_up >= LSC;
    rel_all  = !m_soft && m_up >= LSC + STG;
    chk(nm, !rel_core, !rel_all, rel_all, m_soft && m_soft_age >= HLD);
  endtask

  // Inputs change 1 time unit after an edge; outputs sampled 1 unit after the next edge.
  task automatic step(input logic lk, input logic rq, input logic rn);
    locked = lk; req = rq;
    if (!rn) begin rst_n = 1'b0; model_reset(); end
    else rst_n = 1'b1;
    @(posedge clk);
    if (rst_n) model_edge(lk, rq);
    #1;
  endtask

  typedef struct {
    logic lk; logic rq; int n;
    logic c; logic p; logic r; logic a;
    string nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic lk, rq, rn;
    int   lk_low;

    // {locked, req, cycles, core, periph, ready, ack}
    tbl.push_back('{1,0,18, 1,1,0,0, "pwr_hold"});
    tbl.push_back('{1,0, 4, 0,1,0,0, "pwr_core_rel"});
    tbl.push_back('{1,0, 3, 0,0,1,0, "pwr_run"});
    tbl.push_back('{1,1,16, 1,1,0,0, "soft_hold"});
    tbl.push_back('{1,1, 6, 1,1,0,1, "soft_ack"});
    tbl.push_back('{1,0, 4, 0,1,0,0, "soft_core_rel"});
    tbl.push_back('{1,0, 3, 0,0,1,0, "soft_run"});
    tbl.push_back('{0,0, 2, 0,0,1,0, "loss_sync"});
    tbl.push_back('{0,0, 3, 1,1,0,0, "loss_reset"});
    tbl.push_back('{1,0,12, 1,1,0,0, "stab_pre"});
    tbl.push_back('{0,0, 3, 1,1,0,0, "stab_glitch"});
    tbl.push_back('{1,0,18, 1,1,0,0, "stab_restart"});
    tbl.push_back('{1,0, 4, 0,1,0,0, "stab_core_rel"});
    tbl.push_back('{1,0, 2, 0,0,1,0, "stab_run"});
    tbl.push_back('{1,1,16, 1,1,0,0, "sa_hold"});
    tbl.push_back('{1,1, 2, 1,1,0,1, "sa_ack"});
    tbl.push_back('{0,1, 2, 1,1,0,1, "sa_loss_sync"});
    tbl.push_back('{0,1, 1, 1,1,0,0, "sa_ack_drop"});
    tbl.push_back('{1,1,18, 1,1,0,0, "sa_relock"});
    tbl.push_back('{1,1, 4, 0,1,0,0, "sa_core_rel"});
    tbl.push_back('{1,1, 1, 0,0,1,0, "sa_run"});
    tbl.push_back('{1,1,16, 1,1,0,0, "sa_rereq_hold"});
    tbl.push_back('{1,1, 1, 1,1,0,1, "sa_rereq_ack"});
    tbl.push_back('{1,0, 4, 0,1,0,0, "sa_core_rel2"});
    tbl.push_back('{1,0, 2, 0,0,1,0, "sa_run2"});

    model_reset();
    #2 rst_n = 1'b0;
    #1 chk("reset_async", 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      chk("reset_hold", 1, 1, 0, 0);
    end

    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) begin
        step(tbl[k].lk, tbl[k].rq, 1);
        chk(tbl[k].nm, tbl[k].c, tbl[k].p, tbl[k].r, tbl[k].a);
      end
    end

    // Async reset pulsed between edges while in RUN.
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk("async_mid_run", 1, 1, 0, 0);
    step(1, 0, 0);
    chk("async_held", 1, 1, 0, 0);
    for (int i = 0; i < 18; i++) begin
      step(1, 0, 1);
      chk("async_reseq_hold", 1, 1, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1);
      chk("async_reseq_core", 0, 1, 0, 0);
    end
    step(1, 0, 1);
    chk("async_reseq_run", 0, 0, 1, 0);
    chk_model("model_sync");

    lk = 1; rq = 0; lk_low = 0;
    for (int i = 0; i < 5000; i++) begin
      if (lk_low > 0) lk_low--;
      else if ($urandom_range(0, 149) == 0) lk_low = $urandom_range(1, 6);
      lk = (lk_low == 0);
      if ($urandom_range(0, 39) == 0) rq = !rq;
      rn = ($urandom_range(0, 1999) != 0);
      step(lk, rq, rn);
      chk_model("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
